// File: rtl/btle_pkg.sv
// btle_pkg: shared types and constants for the BTLE receive path.
//   rx_state_e     - receiver FSM states
//   AA_BIT_WIDTH   - access address length in bits
//   CRC_BIT_COUNT  - CRC24 trailer length in bits
//   ADV_CHANNEL_*  - advertising channel indices (6-bit length field)
//   CRC24_POLY     - CRC24 feedback taps (x^24+x^10+x^9+x^6+x^4+x^3+x+1)
package btle_pkg;

  typedef enum logic [1:0] {
    ST_SEARCH,
    ST_RX_HEADER,
    ST_RX_PAYLOAD,
    ST_RX_CRC
  } rx_state_e;

  localparam int unsigned AA_BIT_WIDTH  = 32;
  localparam int unsigned CRC_BIT_COUNT = 24;

  localparam int unsigned ADV_CHANNEL_0 = 37;
  localparam int unsigned ADV_CHANNEL_1 = 38;
  localparam int unsigned ADV_CHANNEL_2 = 39;

  localparam logic [23:0] CRC24_POLY = 24'h00065B;

  function automatic logic is_adv_channel(input int unsigned ch);
    return (ch == ADV_CHANNEL_0) || (ch == ADV_CHANNEL_1) || (ch == ADV_CHANNEL_2);
  endfunction

endpackage

// File: rtl/btle_aa_correlator.sv
// btle_aa_correlator: access-address shift register and exact-match compare.
//   clear          - zero the shift register (priority over shift)
//   shift          - shift phy_bit in at the MSB (LSB-first on air)
//   phy_bit        - incoming bit
//   access_address - expected address
//   match          - combinational: the post-shift value equals access_address
module btle_aa_correlator #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             shift,
  input  logic             phy_bit,
  input  logic [WIDTH-1:0] access_address,
  output logic             match
);

  logic [WIDTH-1:0] aa_sr;
  logic [WIDTH-1:0] aa_sr_next;

  always_comb begin
    aa_sr_next = {phy_bit, aa_sr[WIDTH-1:1]};
    match      = shift && (aa_sr_next == access_address);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aa_sr <= '0;
    end else if (clear) begin
      aa_sr <= '0;
    end else if (shift) begin
      aa_sr <= aa_sr_next;
    end
  end

endmodule

// File: rtl/crc24_core.sv
// crc24_core: BTLE CRC24 LFSR with explicit load/step control.
//   load      - preset state with init
//   init      - CRC init value (bit i -> register position i)
//   step      - clock one data bit through the LFSR
//   data_bit  - data bit to absorb
//   crc_state - current state; position 23 is transmitted first
module crc24_core
  import btle_pkg::*;
#(
  parameter int unsigned CRC_STATE_BIT_WIDTH = 24
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           load,
  input  logic [CRC_STATE_BIT_WIDTH-1:0] init,
  input  logic                           step,
  input  logic                           data_bit,
  output logic [CRC_STATE_BIT_WIDTH-1:0] crc_state
);

  logic fb;

  always_comb begin
    fb = data_bit ^ crc_state[CRC_STATE_BIT_WIDTH-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_state <= '0;
    end else if (load) begin
      crc_state <= init;
    end else if (step) begin
      crc_state <= {crc_state[CRC_STATE_BIT_WIDTH-2:0], 1'b0}
                 ^ ({CRC_STATE_BIT_WIDTH{fb}} & CRC_STATE_BIT_WIDTH'(CRC24_POLY));
    end
  end

endmodule

// File: rtl/scramble_core.sv
// scramble_core: BTLE whitening LFSR (x^7+x^4+1).
//   load           - seed LFSR with {1, channel_number}
//   channel_number - whitening seed
//   step           - advance one bit
//   whiten_bit     - current whitening bit (XOR with the data bit)
// lfsr[6] holds register position 0, lfsr[0] holds position 6 (the output).
module scramble_core #(
  parameter int unsigned CHANNEL_NUMBER_BIT_WIDTH = 6
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                load,
  input  logic [CHANNEL_NUMBER_BIT_WIDTH-1:0] channel_number,
  input  logic                                step,
  output logic                                whiten_bit
);

  logic [6:0] lfsr;

  assign whiten_bit = lfsr[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= '0;
    end else if (load) begin
      lfsr <= 7'({1'b1, channel_number});
    end else if (step) begin
      lfsr <= {lfsr[0], lfsr[6:4], lfsr[3] ^ lfsr[0], lfsr[2:1]};
    end
  end

endmodule

// File: rtl/btle_rx_core.sv
// btle_rx_core: bit-level BTLE link-layer receiver.
//   rx_enable                - 1 = receive, 0 = abort and hold in SEARCH
//   access_address           - expected access address (LSB first on air)
//   crc_state_init_bit(_load)- CRC init value and its latch strobe
//   channel_number(_load)    - whitening seed and its latch strobe
//   phy_bit / phy_bit_valid  - demodulated bit and per-bit strobe
//   aa_hit                   - pulse on access-address match
//   info_bit(_valid)         - de-whitened PDU/CRC bit
//   pdu_octet_mem_*          - PDU octet write port (CRC octets not written)
//   payload_length           - decoded length, 7'h7f until header decoded
//   packet_done / crc_ok     - completion pulse and CRC result
module btle_rx_core
  import btle_pkg::*;
#(
  parameter int unsigned CRC_STATE_BIT_WIDTH      = 24,
  parameter int unsigned CHANNEL_NUMBER_BIT_WIDTH = 6,
  parameter int unsigned OCTET_ADDR_BIT_WIDTH     = 6
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                rx_enable,
  input  logic [31:0]                         access_address,
  input  logic [CRC_STATE_BIT_WIDTH-1:0]      crc_state_init_bit,
  input  logic                                crc_state_init_bit_load,
  input  logic [CHANNEL_NUMBER_BIT_WIDTH-1:0] channel_number,
  input  logic                                channel_number_load,
  input  logic                                phy_bit,
  input  logic                                phy_bit_valid,
  output logic                                aa_hit,
  output logic                                info_bit,
  output logic                                info_bit_valid,
  output logic [7:0]                          pdu_octet_mem_data,
  output logic [OCTET_ADDR_BIT_WIDTH-1:0]     pdu_octet_mem_addr,
  output logic                                pdu_octet_mem_we,
  output logic [6:0]                          payload_length,
  output logic                                packet_done,
  output logic                                crc_ok
);

  localparam logic [4:0] CRC_LAST    = 5'(CRC_BIT_COUNT - 1);
  localparam logic [6:0] OCTET_LIMIT = 7'(1 << OCTET_ADDR_BIT_WIDTH);

  rx_state_e                         state;
  logic [CHANNEL_NUMBER_BIT_WIDTH-1:0] chan_reg;
  logic [CRC_STATE_BIT_WIDTH-1:0]    crc_init_reg;
  logic [CRC_STATE_BIT_WIDTH-1:0]    crc_state;
  logic [7:0]                        octet;
  logic [7:0]                        octet_next;
  logic [4:0]                        bit_cnt;
  logic [4:0]                        crc_idx;
  logic [6:0]                        oct_cnt;
  logic [6:0]                        hdr_len;
  logic                              pkt_adv;
  logic                              ok_flag;
  logic                              in_pkt;
  logic                              aa_shift;
  logic                              aa_match;
  logic                              aa_clear;
  logic                              whiten_bit;
  logic                              whiten_step;
  logic                              crc_step;
  logic                              crc_bit_ok;
  logic                              done_now;

  assign pdu_octet_mem_data = octet;

  always_comb begin
    in_pkt      = (state != ST_SEARCH);
    aa_shift    = rx_enable && !in_pkt && phy_bit_valid;
    whiten_step = rx_enable && in_pkt && phy_bit_valid;
    crc_step    = rx_enable && info_bit_valid
                  && (state == ST_RX_HEADER || state == ST_RX_PAYLOAD);
    octet_next  = {info_bit, octet[7:1]};
    hdr_len     = pkt_adv ? {1'b0, octet_next[5:0]} : {2'b00, octet_next[4:0]};
    crc_idx     = CRC_LAST - bit_cnt;
    crc_bit_ok  = (info_bit == crc_state[crc_idx]);
    done_now    = rx_enable && info_bit_valid && (state == ST_RX_CRC) && (bit_cnt == CRC_LAST);
    aa_clear    = !rx_enable || done_now;
  end

  btle_aa_correlator #(
    .WIDTH(AA_BIT_WIDTH)
  ) u_aa (
    .clk           (clk),
    .rst_n         (rst_n),
    .clear         (aa_clear),
    .shift         (aa_shift),
    .phy_bit       (phy_bit),
    .access_address(access_address),
    .match         (aa_match)
  );

  scramble_core #(
    .CHANNEL_NUMBER_BIT_WIDTH(CHANNEL_NUMBER_BIT_WIDTH)
  ) u_whiten (
    .clk           (clk),
    .rst_n         (rst_n),
    .load          (aa_match),
    .channel_number(chan_reg),
    .step          (whiten_step),
    .whiten_bit    (whiten_bit)
  );

  crc24_core #(
    .CRC_STATE_BIT_WIDTH(CRC_STATE_BIT_WIDTH)
  ) u_crc (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (aa_match),
    .init     (crc_init_reg),
    .step     (crc_step),
    .data_bit (info_bit),
    .crc_state(crc_state)
  );

  // Two-stage bit path: stage 1 de-whitens phy_bit into info_bit; stage 2
  // (on info_bit_valid) assembles octets, feeds/compares CRC and sequences.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= ST_SEARCH;
      chan_reg           <= '0;
      crc_init_reg       <= '0;
      aa_hit             <= 1'b0;
      info_bit           <= 1'b0;
      info_bit_valid     <= 1'b0;
      octet              <= '0;
      bit_cnt            <= '0;
      oct_cnt            <= '0;
      pdu_octet_mem_addr <= '0;
      pdu_octet_mem_we   <= 1'b0;
      payload_length     <= 7'h7f;
      packet_done        <= 1'b0;
      crc_ok             <= 1'b0;
      ok_flag            <= 1'b0;
      pkt_adv            <= 1'b0;
    end else begin
      aa_hit           <= 1'b0;
      info_bit_valid   <= 1'b0;
      pdu_octet_mem_we <= 1'b0;
      packet_done      <= 1'b0;

      if (channel_number_load)     chan_reg     <= channel_number;
      if (crc_state_init_bit_load) crc_init_reg <= crc_state_init_bit;

      if (pdu_octet_mem_we && (pdu_octet_mem_addr != '1)) begin
        pdu_octet_mem_addr <= pdu_octet_mem_addr + 1'b1;
      end

      if (!rx_enable) begin
        state              <= ST_SEARCH;
        bit_cnt            <= '0;
        oct_cnt            <= '0;
        pdu_octet_mem_addr <= '0;
      end else if (state == ST_SEARCH) begin
        if (aa_match) begin
          aa_hit             <= 1'b1;
          state              <= ST_RX_HEADER;
          bit_cnt            <= '0;
          oct_cnt            <= '0;
          pdu_octet_mem_addr <= '0;
          payload_length     <= 7'h7f;
          ok_flag            <= 1'b1;
          pkt_adv            <= is_adv_channel(32'(chan_reg));
        end
      end else begin
        if (phy_bit_valid) begin
          info_bit       <= phy_bit ^ whiten_bit;
          info_bit_valid <= 1'b1;
        end

        if (info_bit_valid) begin
          if (state == ST_RX_CRC) begin
            ok_flag <= ok_flag && crc_bit_ok;
            bit_cnt <= bit_cnt + 5'd1;
            if (done_now) begin
              packet_done <= 1'b1;
              crc_ok      <= ok_flag && crc_bit_ok;
              state       <= ST_SEARCH;
            end
          end else begin
            octet   <= octet_next;
            bit_cnt <= (bit_cnt == 5'd7) ? 5'd0 : bit_cnt + 5'd1;
            if (bit_cnt == 5'd7) begin
              oct_cnt          <= oct_cnt + 7'd1;
              pdu_octet_mem_we <= (oct_cnt < OCTET_LIMIT);
              if (state == ST_RX_HEADER) begin
                if (oct_cnt == 7'd1) begin
                  payload_length <= hdr_len;
                  state          <= (hdr_len == '0) ? ST_RX_CRC : ST_RX_PAYLOAD;
                end
              end else if ((oct_cnt + 7'd1) == (payload_length + 7'd2)) begin
                state <= ST_RX_CRC;
              end
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_btle_rx_core.sv
module tb_btle_rx_core;

  typedef bit         bit_q_t[$];
  typedef logic [7:0] byte_q_t[$];

  localparam logic [31:0] AA = 32'h8E89BED6;
  localparam int K_HIT  = 0;
  localparam int K_WR   = 1;
  localparam int K_DONE = 2;

  typedef struct {
    int          kind;
    logic [31:0] a;
    logic [31:0] d;
  } ev_t;

  ev_t sb[$];
  int  tests = 0;
  int  fails = 0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_enable = 1'b0;
  logic [31:0] access_address = AA;
  logic [23:0] crc_state_init_bit = '0;
  logic        crc_state_init_bit_load = 1'b0;
  logic [5:0]  channel_number = '0;
  logic        channel_number_load = 1'b0;
  logic        phy_bit = 1'b0;
  logic        phy_bit_valid = 1'b0;
  logic        aa_hit;
  logic        info_bit;
  logic        info_bit_valid;
  logic [7:0]  pdu_octet_mem_data;
  logic [5:0]  pdu_octet_mem_addr;
  logic        pdu_octet_mem_we;
  logic [6:0]  payload_length;
  logic        packet_done;
  logic        crc_ok;

  btle_rx_core #(
    .CRC_STATE_BIT_WIDTH     (24),
    .CHANNEL_NUMBER_BIT_WIDTH(6),
    .OCTET_ADDR_BIT_WIDTH    (6)
  ) dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .rx_enable              (rx_enable),
    .access_address         (access_address),
    .crc_state_init_bit     (crc_state_init_bit),
    .crc_state_init_bit_load(crc_state_init_bit_load),
    .channel_number         (channel_number),
    .channel_number_load    (channel_number_load),
    .phy_bit                (phy_bit),
    .phy_bit_valid          (phy_bit_valid),
    .aa_hit                 (aa_hit),
    .info_bit               (info_bit),
    .info_bit_valid         (info_bit_valid),
    .pdu_octet_mem_data     (pdu_octet_mem_data),
    .pdu_octet_mem_addr     (pdu_octet_mem_addr),
    .pdu_octet_mem_we       (pdu_octet_mem_we),
    .payload_length         (payload_length),
    .packet_done            (packet_done),
    .crc_ok                 (crc_ok)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void push_ev(input int kind, input logic [31:0] a, input logic [31:0] d);
    ev_t e;
    e.kind = kind;
    e.a    = a;
    e.d    = d;
    sb.push_back(e);
  endfunction

  function automatic void expect_pkt(input byte_q_t pdu, input int n_wr, input bit done,
                                     input bit ok, input int len);
    push_ev(K_HIT, 0, 0);
    for (int i = 0; i < n_wr; i++) push_ev(K_WR, i, pdu[i]);
    if (done) push_ev(K_DONE, 32'(ok), len);
  endfunction

  task automatic on_event(input int kind, input logic [31:0] a, input logic [31:0] d);
    ev_t e;
    if (sb.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL unexpected_output: kind %0d a=0x%0h d=0x%0h, expected no output", kind, a, d);
    end else begin
      e = sb.pop_front();
      chk("event_kind", kind, e.kind);
      if (kind == e.kind) begin
        if (kind == K_WR) begin
          chk("wr_addr", a, e.a);
          chk("wr_data", d, e.d);
        end else if (kind == K_DONE) begin
          chk("crc_ok", a, e.a);
          chk("payload_length", d, e.d);
        end
      end
    end
  endtask

  // Monitor: compares every DUT output event against the scoreboard queue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (aa_hit)           on_event(K_HIT, 0, 0);
      if (pdu_octet_mem_we) on_event(K_WR, 32'(pdu_octet_mem_addr), 32'(pdu_octet_mem_data));
      if (packet_done)      on_event(K_DONE, 32'(crc_ok), 32'(payload_length));
    end
  end

  // Transmit-side model: AA (unwhitened), PDU + CRC24 trailer, whitened.
  function automatic void build_pkt(input logic [31:0] aa, input logic [5:0] ch,
                                    input logic [23:0] init, input byte_q_t pdu,
                                    output bit_q_t bits);
    logic [6:0]  w;
    logic [23:0] s;
    logic [7:0]  by;
    logic        d, fb;
    bits = {};
    for (int i = 0; i < 32; i++) bits.push_back(aa[i]);
    w[0] = 1'b1;
    for (int k = 1; k < 7; k++) w[k] = ch[6-k];
    s = init;
    foreach (pdu[n]) begin
      by = pdu[n];
      for (int j = 0; j < 8; j++) begin
        d  = by[j];
        fb = d ^ s[23];
        s  = {s[22:10], s[9]^fb, s[8]^fb, s[7], s[6], s[5]^fb, s[4],
              s[3]^fb, s[2]^fb, s[1], s[0]^fb, fb};
        bits.push_back(d ^ w[6]);
        w = {w[5], w[4], w[3]^w[6], w[2], w[1], w[0], w[6]};
      end
    end
    for (int k = 23; k >= 0; k--) begin
      bits.push_back(s[k] ^ w[6]);
      w = {w[5], w[4], w[3]^w[6], w[2], w[1], w[0], w[6]};
    end
  endfunction

  task automatic send_bits(input bit_q_t bits, input int from, input int to, input int spacing);
    for (int i = from; i < to; i++) begin
      phy_bit       = bits[i];
      phy_bit_valid = 1'b1;
      @(posedge clk); #1;
      phy_bit_valid = 1'b0;
      repeat (spacing - 1) @(posedge clk);
      #1;
    end
  endtask

  task automatic load_cfg(input logic [5:0] ch, input logic [23:0] init);
    channel_number          = ch;
    channel_number_load     = 1'b1;
    crc_state_init_bit      = init;
    crc_state_init_bit_load = 1'b1;
    @(posedge clk); #1;
    channel_number_load     = 1'b0;
    crc_state_init_bit_load = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_aa_hit"},         32'(aa_hit), 0);
    chk({tag, "_info_valid"},     32'(info_bit_valid), 0);
    chk({tag, "_we"},             32'(pdu_octet_mem_we), 0);
    chk({tag, "_addr"},           32'(pdu_octet_mem_addr), 0);
    chk({tag, "_data"},           32'(pdu_octet_mem_data), 0);
    chk({tag, "_payload_length"}, 32'(payload_length), 32'h7f);
    chk({tag, "_packet_done"},    32'(packet_done), 0);
    chk({tag, "_crc_ok"},         32'(crc_ok), 0);
  endtask

  initial begin
    byte_q_t p1, p3, pbig;
    bit_q_t  b1, b3, b, gap;

    p1 = {8'h00, 8'h06, 8'h3C, 8'hA5, 8'h0F, 8'h81, 8'h7E, 8'hD2};
    p3 = {8'h02, 8'hE5, 8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'h5E};
    pbig = {8'h00, 8'h3F};
    for (int i = 0; i < 63; i++) pbig.push_back(8'((i * 7 + 3) & 8'hff));
    gap = {1'b1, 1'b0, 1'b1, 1'b1};
    build_pkt(AA, 6'd37, 24'h555555, p1, b1);
    build_pkt(AA, 6'd12, 24'h123456, p3, b3);

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_idle("reset");
    @(posedge clk); #1;
    rx_enable = 1'b1;
    load_cfg(6'd37, 24'h555555);

    // Advertising packet, length 6
    expect_pkt(p1, 8, 1, 1, 6);
    send_bits(b1, 0, b1.size(), 16);

    // Same packet, 10th CRC bit corrupted
    b = b1;
    b[32 + 64 + 9] = ~b[32 + 64 + 9];
    expect_pkt(p1, 8, 1, 0, 6);
    send_bits(b, 0, b.size(), 16);

    // Data channel 12: 5-bit length field from 0xE5
    load_cfg(6'd12, 24'h123456);
    expect_pkt(p3, 7, 1, 1, 5);
    send_bits(b3, 0, b3.size(), 16);

    // Access address with one bit error, then a valid packet
    load_cfg(6'd37, 24'h555555);
    b = b1;
    b[13] = ~b[13];
    send_bits(b, 0, b.size(), 16);
    expect_pkt(p1, 8, 1, 1, 6);
    send_bits(b1, 0, b1.size(), 16);

    // Reset pulse at payload bit 20
    expect_pkt(p1, 4, 0, 0, 0);
    send_bits(b1, 0, 32 + 16 + 20, 16);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_idle("midreset");
    chk("sb_empty_at_reset", sb.size(), 0);
    @(posedge clk); #1;
    load_cfg(6'd37, 24'h555555);
    expect_pkt(p1, 8, 1, 1, 6);
    send_bits(b1, 0, b1.size(), 16);

    // Back-to-back packets with 4-bit gap; config for the next packet is
    // reloaded while the current one is still in flight.
    b = {b1, gap, b3};
    expect_pkt(p1, 8, 1, 1, 6);
    expect_pkt(p3, 7, 1, 1, 5);
    fork
      send_bits(b, 0, b.size(), 16);
      begin
        repeat (1000) @(posedge clk);
        #1 load_cfg(6'd12, 24'h123456);
        repeat (1600) @(posedge clk);
        #1 load_cfg(6'd37, 24'h555555);
      end
    join

    // Third packet aborted by rx_enable after 24 PDU bits
    expect_pkt(p1, 3, 0, 0, 0);
    send_bits(b1, 0, 32 + 24, 16);
    repeat (4) @(posedge clk);
    #1 rx_enable = 1'b0;
    send_bits(b1, 32 + 24, b1.size(), 16);
    chk("abort_payload_length_kept", 32'(payload_length), 6);
    chk("abort_crc_ok_kept", 32'(crc_ok), 1);
    rx_enable = 1'b1;
    @(posedge clk); #1;
    expect_pkt(p1, 8, 1, 1, 6);
    send_bits(b1, 0, b1.size(), 16);

    // Max advertising length 63 -> 65 octets, last one suppressed; 2-cycle spacing
    build_pkt(AA, 6'd37, 24'h555555, pbig, b);
    expect_pkt(pbig, 64, 1, 1, 63);
    send_bits(b, 0, b.size(), 2);
    @(negedge clk);
    chk("addr_saturated", 32'(pdu_octet_mem_addr), 63);

    repeat (100) @(posedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/btle_rx_core.md
Name: btle_rx_core

Overview:
- Bit-level BTLE link-layer receiver; the receive-side counterpart of btle_tx.
- Consumes hard-decision demodulated phy bits, one valid strobe per symbol, from the GFSK demodulator.
- Searches for the 32-bit access address, de-whitens, extracts the PDU length and checks CRC24.
- Writes PDU octets into the rx octet dpram and reports packet completion and CRC status to the controller.

Parameters:
CRC_STATE_BIT_WIDTH, 24, CRC LFSR width
CHANNEL_NUMBER_BIT_WIDTH, 6, channel number width
OCTET_ADDR_BIT_WIDTH, 6, PDU octet memory address width

Ports:
clk  in  1  system clock (16 MHz)
rst_n  in  1  asynchronous, active-low reset
rx_enable  in  1  1 = receive; 0 = abort and hold in SEARCH
access_address  in  32  expected access address, LSB first on air
crc_state_init_bit  in  24  CRC init value; latched on crc_state_init_bit_load
crc_state_init_bit_load  in  1  latch strobe for CRC init
channel_number  in  6  whitening seed; latched on channel_number_load
channel_number_load  in  1  latch strobe for channel number
phy_bit  in  1  demodulated bit
phy_bit_valid  in  1  one-cycle strobe per bit; arbitrary spacing of at least 2 cycles
aa_hit  out  1  one-cycle pulse on access-address match
info_bit  out  1  de-whitened PDU/CRC bit
info_bit_valid  out  1  strobe for info_bit
pdu_octet_mem_data  out  8  assembled octet
pdu_octet_mem_addr  out  6  octet index, starting at 0
pdu_octet_mem_we  out  1  one-cycle write enable
payload_length  out  7  decoded length; 7'h7f until the header is decoded
packet_done  out  1  one-cycle pulse after the last CRC bit
crc_ok  out  1  CRC result; valid at packet_done, held until the next aa_hit

Behaviour:
- Reset values: all outputs 0 except payload_length = 7'h7f. State = SEARCH. Latched crc_init/channel registers = 0. AA shift register = 0.
- Load strobes update the latched registers in any state. The latched values are applied only at aa_hit, so a load mid-packet does not affect the current packet.
- States: SEARCH -> RX_HEADER -> RX_PAYLOAD -> RX_CRC -> SEARCH.
- SEARCH:
  - On phy_bit_valid: aa_sr <= {phy_bit, aa_sr[31:1]}.
  - If the updated aa_sr == access_address (exact match), assert aa_hit on the next cycle and go to RX_HEADER.
  - On entry to RX_HEADER: whitening LFSR (x^7+x^4+1) loads {1, channel_number}, CRC LFSR loads crc_state_init_bit, bit/octet counters clear.
- De-whitening: every valid bit after aa_hit is XORed with the whitening LFSR output, then the LFSR steps. Behaviour is bit-exact inverse of scramble_core. info_bit/info_bit_valid are registered, 1 cycle after phy_bit_valid.
- Octet assembly: LSB first; octet <= {bit, octet[7:1]}.
  - The cycle after the 8th bit's info_bit_valid: pdu_octet_mem_we = 1 with the current addr; addr then increments.
- RX_HEADER: 16 bits.
  - At the octet-1 write: payload_length = adv ? {1'b0, octet[5:0]} : {2'b0, octet[4:0]}, where adv = latched channel is 37, 38 or 39.
  - Then go to RX_PAYLOAD, or directly to RX_CRC if the length is 0.
- RX_PAYLOAD: each de-whitened bit feeds the CRC LFSR (polynomial identical to crc24_core). Ends after (payload_length+2)*8 total PDU bits.
- RX_CRC: the next 24 de-whitened bits are compared serially with the frozen CRC state, in the same order crc24 appends them.
  - Any mismatch clears the running ok flag.
  - The cycle after the 24th bit's info_bit_valid: packet_done = 1, crc_ok = flag, state = SEARCH, aa_sr cleared.
  - CRC octets are not written to memory.
- Octet index >= 64 (adv length 63 gives 65 octets): write suppressed, addr saturates at 63, CRC still computed.
- rx_enable = 0 in any state: next cycle state = SEARCH; aa_sr, counters and we cleared; no packet_done. crc_ok and payload_length keep their last values.
- rst_n asserted mid-packet: immediate return to reset values.
- phy_bit_valid on the same cycle as a load strobe: both take effect.

Decomposition:
- btle_pkg: state encodings, ADV channel numbers 37/38/39, AA_BIT_WIDTH = 32, CRC_BIT_COUNT = 24.
- Reuse scramble_core and crc24_core as sub-modules: shared polynomials, driven with an explicit load/step interface.
- One new sub-module, btle_aa_correlator: the shift register plus equality compare, so a thresholded Hamming version can replace it later.

Test Plan:
- AA 0x8E89BED6, channel 37, crc init 0x555555, PDU 0x00 0x06 plus 6 bytes generated by btle_tx, bits at 16-clock spacing -> aa_hit once; 8 writes at addr 0..7 matching the bytes; payload_length 6; packet_done with crc_ok = 1.
- Same packet with the 10th CRC bit flipped -> identical octet writes, crc_ok = 0.
- Channel 12, header octet1 = 0xE5 -> payload_length 5 (5-bit field); 7 writes; crc_ok = 1.
- Access address with 1 bit error, followed by a valid packet -> no hit on the first; the second is received correctly.
- rst_n low for 1 cycle at payload bit 20 -> outputs at reset values; the next full packet is received with crc_ok = 1.
- Two packets back-to-back with a 4-bit gap; rx_enable dropped mid-way through a third -> two packet_done pulses, no third pulse, state SEARCH.
